// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// FETCH_PERF_CNT_EN (optional) enables the fetch/stall/flush counter widths used by fetch_unit.
package fetch_unit_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // Encoding the decode side substitutes into slots where if_valid is low
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    localparam int unsigned FETCH_CNT_W = 32;
    localparam int unsigned STALL_CNT_W = 32;
    localparam int unsigned FLUSH_CNT_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode/execute control in, instruction memory port, IF/ID payload out.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instruction;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instruction,
        output imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instruction,
        input  imem_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs returned instructions with their PC,
// holds the presented slot across decode stalls and flushes on redirect. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [FETCH_CNT_W-1:0] fetch_count,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [FLUSH_CNT_W-1:0] flush_count
`endif
);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               fetch_valid_q;
    logic [INSTR_W-1:0] hold_instr;
    fetch_state_t       state;
    logic               holding;

    assign holding = (state == HOLD);

    // Redirect beats stall beats advance; the memory's registered read lines up with fetch_pc_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            hold_instr    <= '0;
            state         <= RUN;
        end else if (bus.redirect_valid) begin
            pc            <= bus.redirect_target;
            fetch_pc_q    <= pc;
            fetch_valid_q <= 1'b0;
            state         <= RUN;
        end else if (bus.stall) begin
            if (state == RUN) begin
                hold_instr <= bus.imem_instruction;
                state      <= HOLD;
            end
        end else begin
            pc            <= pc + ADDR_W'(1);
            fetch_pc_q    <= pc;
            fetch_valid_q <= 1'b1;
            state         <= RUN;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.if_pc     = fetch_pc_q;
    assign bus.if_valid  = fetch_valid_q;
    assign bus.if_instr  = holding ? hold_instr : bus.imem_instruction;

`ifdef FETCH_PERF_CNT_EN
    logic advance;
    assign advance = !bus.redirect_valid && !bus.stall;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (advance && fetch_valid_q && (fetch_count != '1))
                fetch_count <= fetch_count + FETCH_CNT_W'(1);
            if (holding && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);
            if (bus.redirect_valid && (flush_count != '1))
                flush_count <= flush_count + FLUSH_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction model feeds an expectation queue popped after each edge.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t        sb[$];
    logic [15:0] m_pc, m_fpc, m_instr;
    logic        m_valid, m_hold;
    int          m_fetch, m_stall, m_flush;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
    logic [15:0] flush_count;
`endif

    fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Instruction memory with one-cycle registered read
    always @(posedge clk) bus.imem_instruction <= mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_fpc = 16'h0000; m_valid = 1'b0; m_hold = 1'b0; m_instr = 16'h0000;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    // Called at a negedge: drive, predict, clock, compare, return at the next negedge
    task automatic step(input string tag, input logic s, input logic r, input logic [15:0] t);
        exp_t e;
        bus.stall = s; bus.redirect_valid = r; bus.redirect_target = t;
        if (r) m_flush++;
        if (m_hold) m_stall++;
        if (!r && !s && m_valid) m_fetch++;
        if (r) begin
            m_fpc = m_pc; m_valid = 1'b0; m_pc = t; m_hold = 1'b0;
        end else if (s) begin
            m_hold = 1'b1;
        end else begin
            m_fpc = m_pc; m_valid = 1'b1; m_instr = mem_word(m_pc); m_pc = m_pc + 16'd1; m_hold = 1'b0;
        end
        e.v = m_valid; e.pc = m_fpc; e.ins = m_instr; e.addr = m_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, 32'(bus.if_valid), 32'(e.v));
        chk({tag, ".pc"},    32'(bus.if_pc),    32'(e.pc));
        chk({tag, ".addr"},  32'(bus.imem_addr), 32'(e.addr));
        if (e.v) chk({tag, ".instr"}, 32'(bus.if_instr), 32'(e.ins));
        @(negedge clk);
    endtask

    initial begin
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 16'h0000;
        reset_n = 1'b0;
        model_reset();
        #12;
        chk("rst.valid", 32'(bus.if_valid), 32'd0);
        chk("rst.pc",    32'(bus.if_pc),    32'(RESET_PC));
        chk("rst.addr",  32'(bus.imem_addr), 32'(RESET_PC));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) step("seq", 1'b0, 1'b0, 16'h0);   // up to if_pc=5
        for (int i = 0; i < 3; i++) step("stall3", 1'b1, 1'b0, 16'h0);
        step("post_stall", 1'b0, 1'b0, 16'h0);                         // if_pc=6
        step("seq7", 1'b0, 1'b0, 16'h0);                               // if_pc=7
        step("redir40", 1'b0, 1'b1, 16'h0040);
        step("tgt40", 1'b0, 1'b0, 16'h0);
        step("seq41", 1'b0, 1'b0, 16'h0);

        step("hold_a", 1'b1, 1'b0, 16'h0);
        step("hold_b", 1'b1, 1'b0, 16'h0);
        step("redir_stall", 1'b1, 1'b1, 16'h0080);
        step("tgt80", 1'b0, 1'b0, 16'h0);
        step("seq81", 1'b0, 1'b0, 16'h0);

        step("redirFFFF", 1'b0, 1'b1, 16'hFFFF);
        step("tgtFFFF", 1'b0, 1'b0, 16'h0);
        step("wrap0", 1'b0, 1'b0, 16'h0);
        step("wrap1", 1'b0, 1'b0, 16'h0);

        step("redir10", 1'b0, 1'b1, 16'h0010);
        step("bubble_hold_a", 1'b1, 1'b0, 16'h0);
        step("bubble_hold_b", 1'b1, 1'b0, 16'h0);
        step("tgt10", 1'b0, 1'b0, 16'h0);

`ifdef FETCH_PERF_CNT_EN
        chk("cnt.fetch", fetch_count, 32'(m_fetch));
        chk("cnt.stall", stall_count, 32'(m_stall));
        chk("cnt.flush", 32'(flush_count), 32'(m_flush));
`endif

        step("pre_rst_stall", 1'b1, 1'b0, 16'h0);
        reset_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(bus.if_valid), 32'd0);
        chk("async_rst.addr",  32'(bus.imem_addr), 32'(RESET_PC));
        chk("async_rst.pc",    32'(bus.if_pc),    32'(RESET_PC));
        bus.stall = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step("restart", 1'b0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
